instr_fetch_arbiter: RTL

- Shares the single-port instruction memory between two fetch requesters, e.g. two cores or a fetch unit plus a debug/loader port.
- Arbitrates round-robin and drives the memory's enable and byte-address inputs.
- Captures the memory's combinational read data into a per-requester response buffer with valid/ready backpressure.
- Sits between the fetch stages and the instruction memory. No other agent drives the memory port.

---
 rtl/instr_fetch_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between two fetch requesters.
// Optional grant/error statistics counters are enabled with the FETCH_ARB_STATS_EN macro.
module instr_fetch_arbiter #(
    parameter int unsigned MEM_DEPTH = 32,
    parameter logic [31:0] NO_OP     = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        req0_valid_i,
    input  logic [15:0] req0_addr_i,
    output logic        req0_ready_o,
    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_instr_o,
    output logic        rsp0_err_o,
    input  logic        rsp0_ready_i,
    input  logic        req1_valid_i,
    input  logic [15:0] req1_addr_i,
    output logic        req1_ready_o,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_instr_o,
    output logic        rsp1_err_o,
    input  logic        rsp1_ready_i,
    output logic        mem_enable_o,
    output logic [15:0] mem_addr_o,
`ifdef FETCH_ARB_STATS_EN
    output logic [15:0] grant_cnt0_o,
    output logic [15:0] grant_cnt1_o,
    output logic [15:0] err_cnt_o,
`endif
    input  logic [31:0] mem_instr_i
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e    buf0_q, buf0_d, buf1_q, buf1_d;
    logic [DW-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic          last_q, last_d;

    logic elig0, elig1, gnt0, gnt1;
    logic in_range0, in_range1;

    // Full 14-bit word index compared, so high addresses never alias into range.
    assign in_range0 = 32'(req0_addr_i[AW-1:2]) < MEM_DEPTH;
    assign in_range1 = 32'(req1_addr_i[AW-1:2]) < MEM_DEPTH;

    // A full buffer can accept a new fetch in the same cycle its response is consumed.
    assign elig0 = !rst_i && enable_i && req0_valid_i && ((buf0_q == BUF_EMPTY) || rsp0_ready_i);
    assign elig1 = !rst_i && enable_i && req1_valid_i && ((buf1_q == BUF_EMPTY) || rsp1_ready_i);

    assign gnt0 = elig0 && (!elig1 || last_q);
    assign gnt1 = elig1 && (!elig0 || !last_q);

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign mem_enable_o = gnt0 || gnt1;
    assign mem_addr_o   = gnt0 ? req0_addr_i : (gnt1 ? req1_addr_i : '0);

    assign rsp0_valid_o = (buf0_q == BUF_FULL);
    assign rsp1_valid_o = (buf1_q == BUF_FULL);
    assign rsp0_instr_o = instr0_q;
    assign rsp1_instr_o = instr1_q;
    assign rsp0_err_o   = err0_q;
    assign rsp1_err_o   = err1_q;

    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        last_d   = last_q;

        if (gnt0) begin
            buf0_d   = BUF_FULL;
            instr0_d = in_range0 ? mem_instr_i : NO_OP;
            err0_d   = !in_range0;
            last_d   = 1'b0;
        end else if (rsp0_ready_i) begin
            buf0_d = BUF_EMPTY;
        end

        if (gnt1) begin
            buf1_d   = BUF_FULL;
            instr1_d = in_range1 ? mem_instr_i : NO_OP;
            err1_d   = !in_range1;
            last_d   = 1'b1;
        end else if (rsp1_ready_i) begin
            buf1_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf0_q   <= BUF_EMPTY;
            buf1_q   <= BUF_EMPTY;
            instr0_q <= NO_OP;
            instr1_q <= NO_OP;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            last_q   <= last_d;
        end
    end

`ifdef FETCH_ARB_STATS_EN
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d, ecnt_q, ecnt_d;
    logic          err_capture;

    // At most one grant per cycle, so the error counter steps by at most one.
    assign err_capture = (gnt0 && !in_range0) || (gnt1 && !in_range1);

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        ecnt_d  = ecnt_q;
        if (gnt0 && (gcnt0_q != CNT_MAX)) gcnt0_d = gcnt0_q + CW'(1);
        if (gnt1 && (gcnt1_q != CNT_MAX)) gcnt1_d = gcnt1_q + CW'(1);
        if (err_capture && (ecnt_q != CNT_MAX)) ecnt_d = ecnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            ecnt_q  <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign grant_cnt0_o = gcnt0_q;
    assign grant_cnt1_o = gcnt1_q;
    assign err_cnt_o    = ecnt_q;
`endif

endmodule
